// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 register IDs and instruction codes
package y86_pkg;

   typedef logic [3:0] reg_id_t;
   typedef logic [3:0] icode_t;

   localparam reg_id_t RRAX  = 4'h0;
   localparam reg_id_t RRCX  = 4'h1;
   localparam reg_id_t RRDX  = 4'h2;
   localparam reg_id_t RRBX  = 4'h3;
   localparam reg_id_t RRSP  = 4'h4;
   localparam reg_id_t RRBP  = 4'h5;
   localparam reg_id_t RRSI  = 4'h6;
   localparam reg_id_t RRDI  = 4'h7;
   localparam reg_id_t R8    = 4'h8;
   localparam reg_id_t R9    = 4'h9;
   localparam reg_id_t R10   = 4'hA;
   localparam reg_id_t R11   = 4'hB;
   localparam reg_id_t R12   = 4'hC;
   localparam reg_id_t R13   = 4'hD;
   localparam reg_id_t R14   = 4'hE;
   localparam reg_id_t RNONE = 4'hF;

   localparam icode_t IHALT   = 4'h0;
   localparam icode_t INOP    = 4'h1;
   localparam icode_t IRRMOVQ = 4'h2;
   localparam icode_t IIRMOVQ = 4'h3;
   localparam icode_t IRMMOVQ = 4'h4;
   localparam icode_t IMRMOVQ = 4'h5;
   localparam icode_t IOPQ    = 4'h6;
   localparam icode_t IJXX    = 4'h7;
   localparam icode_t ICALL   = 4'h8;
   localparam icode_t IRET    = 4'h9;
   localparam icode_t IPUSHQ  = 4'hA;
   localparam icode_t IPOPQ   = 4'hB;

endpackage

// File: rtl/y86_rf_read_port.sv
// y86_rf_read_port: one register-file read port with ID check and optional write bypass
module y86_rf_read_port
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                ID_W     = 4,
   parameter int                NUM_REGS = 15,
   parameter logic [ID_W-1:0]   RNONE    = '1,
   parameter bit                BYPASS   = 1'b1
) (
   input  logic [ID_W-1:0]   src_i,
   input  logic [DATA_W-1:0] regs_i [NUM_REGS],
   input  logic              wr_e_i,
   input  logic [ID_W-1:0]   dst_e_i,
   input  logic [DATA_W-1:0] val_e_i,
   input  logic              wr_m_i,
   input  logic [ID_W-1:0]   dst_m_i,
   input  logic [DATA_W-1:0] val_m_i,
   output logic [DATA_W-1:0] val_o
);

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REGS - 1);

   logic valid, hit_e, hit_m;

   assign valid = (src_i != RNONE) && (src_i <= LAST_ID);
   // wr_*_i are already qualified by reset and destination range upstream
   assign hit_e = BYPASS && wr_e_i && (dst_e_i == src_i);
   assign hit_m = BYPASS && wr_m_i && (dst_m_i == src_i);
   // M is checked first so a same-ID E/M pair forwards the value that will be stored
   assign val_o = !valid ? '0 : hit_m ? val_m_i : hit_e ? val_e_i : regs_i[src_i];

endmodule

// File: rtl/y86_regfile_2w2r.sv
// y86_regfile_2w2r: Y86-64 register file, two write ports (M over E), two read ports, debug read
module y86_regfile_2w2r
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                ID_W     = 4,
   parameter int                NUM_REGS = 15,
   parameter logic [ID_W-1:0]   RNONE    = '1,
   parameter logic [ID_W-1:0]   SP_ID    = ID_W'(RRSP),
   parameter logic [DATA_W-1:0] SP_RESET = '0,
   parameter bit                BYPASS   = 1'b1,
   parameter bit                REG_READ = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ID_W-1:0]   src_a,
   input  logic [ID_W-1:0]   src_b,
   output logic [DATA_W-1:0] val_a,
   output logic [DATA_W-1:0] val_b,
   input  logic              we_e,
   input  logic [ID_W-1:0]   dst_e,
   input  logic [DATA_W-1:0] val_e,
   input  logic              we_m,
   input  logic [ID_W-1:0]   dst_m,
   input  logic [DATA_W-1:0] val_m,
   input  logic [ID_W-1:0]   dbg_id,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REGS - 1);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              wr_e, wr_m;
   logic [DATA_W-1:0] rd_a, rd_b;

   // A write is live only out of reset and with an implemented destination
   assign wr_e = rst_n && we_e && (dst_e != RNONE) && (dst_e <= LAST_ID);
   assign wr_m = rst_n && we_m && (dst_m != RNONE) && (dst_m <= LAST_ID);

   // Storage: reset clears all but the stack pointer; M is assigned last so it wins a same-ID collision
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         regs_q[SP_ID] <= SP_RESET;
      end else begin
         if (wr_e) regs_q[dst_e] <= val_e;
         if (wr_m) regs_q[dst_m] <= val_m;
      end
   end

   y86_rf_read_port #(
      .DATA_W  (DATA_W),
      .ID_W    (ID_W),
      .NUM_REGS(NUM_REGS),
      .RNONE   (RNONE),
      .BYPASS  (BYPASS)
   ) u_port_a (
      .src_i  (src_a),
      .regs_i (regs_q),
      .wr_e_i (wr_e),
      .dst_e_i(dst_e),
      .val_e_i(val_e),
      .wr_m_i (wr_m),
      .dst_m_i(dst_m),
      .val_m_i(val_m),
      .val_o  (rd_a)
   );

   y86_rf_read_port #(
      .DATA_W  (DATA_W),
      .ID_W    (ID_W),
      .NUM_REGS(NUM_REGS),
      .RNONE   (RNONE),
      .BYPASS  (BYPASS)
   ) u_port_b (
      .src_i  (src_b),
      .regs_i (regs_q),
      .wr_e_i (wr_e),
      .dst_e_i(dst_e),
      .val_e_i(val_e),
      .wr_m_i (wr_m),
      .dst_m_i(dst_m),
      .val_m_i(val_m),
      .val_o  (rd_b)
   );

   // Debug port looks straight at storage, never at in-flight writes
   assign dbg_data = ((dbg_id != RNONE) && (dbg_id <= LAST_ID)) ? regs_q[dbg_id] : '0;

   if (REG_READ) begin : g_reg
      logic [DATA_W-1:0] val_a_q, val_b_q, val_a_d, val_b_d;
      assign val_a_d = rd_en ? rd_a : val_a_q;
      assign val_b_d = rd_en ? rd_b : val_b_q;
      // Read data registers: clear on reset, capture when rd_en is high, otherwise stall
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            val_a_q <= '0;
            val_b_q <= '0;
         end else begin
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
         end
      end
      assign val_a = val_a_q;
      assign val_b = val_b_q;
   end else begin : g_comb
      assign val_a = rd_a;
      assign val_b = rd_b;
   end

endmodule

// File: tb/tb_y86_regfile_2w2r.sv
// tb_y86_regfile_2w2r: directed and randomized checks of the register file against an array model
module tb_y86_regfile_2w2r;

   localparam logic [63:0] SP_RESET = 64'h0;

   logic        clk = 1'b0;
   logic        rst_n, rd_en, we_e, we_m;
   logic [3:0]  src_a, src_b, dst_e, dst_m, dbg_id;
   logic [63:0] val_a, val_b, val_e, val_m, dbg_data;

   logic [63:0] mdl [15];
   logic [63:0] exp_a, exp_b;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   y86_regfile_2w2r dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (rd_en),
      .src_a   (src_a),
      .src_b   (src_b),
      .val_a   (val_a),
      .val_b   (val_b),
      .we_e    (we_e),
      .dst_e   (dst_e),
      .val_e   (val_e),
      .we_m    (we_m),
      .dst_m   (dst_m),
      .val_m   (val_m),
      .dbg_id  (dbg_id),
      .dbg_data(dbg_data)
   );

   function automatic logic [63:0] mdl_rd(input logic [3:0] id);
      return (id < 4'd15) ? mdl[id] : 64'h0;
   endfunction

   // One clock: the model applies the edge's effect, then the bench moves to the negedge
   task automatic tick();
      logic [63:0] nxt [15];
      @(posedge clk);
      if (!rst_n) begin
         foreach (mdl[i]) mdl[i] = 64'h0;
         mdl[4] = SP_RESET;
         exp_a  = 64'h0;
         exp_b  = 64'h0;
      end else begin
         nxt = mdl;
         if (we_e && dst_e < 4'd15) nxt[dst_e] = val_e;
         if (we_m && dst_m < 4'd15) nxt[dst_m] = val_m;
         if (rd_en) begin
            exp_a = (src_a < 4'd15) ? nxt[src_a] : 64'h0;
            exp_b = (src_b < 4'd15) ? nxt[src_b] : 64'h0;
         end
         mdl = nxt;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rd_en = 1'b1; we_e = 1'b0; we_m = 1'b0;
      src_a = 4'h1; src_b = 4'h2; dst_e = 4'h0; dst_m = 4'h0;
      val_e = 64'h0; val_m = 64'h0; dbg_id = 4'h0;
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      n_chk++;
      if (val_a !== 64'h0) begin n_fail++; $display("FAIL reset_val_a got %h want 0", val_a); end
      n_chk++;
      if (val_b !== 64'h0) begin n_fail++; $display("FAIL reset_val_b got %h want 0", val_b); end
      for (int id = 0; id < 16; id++) begin
         dbg_id = 4'(id);
         #1;
         n_chk++;
         if (dbg_data !== ((id == 4) ? SP_RESET : 64'h0)) begin
            n_fail++;
            $display("FAIL reset_dbg[%0d] got %h want %h", id, dbg_data, (id == 4) ? SP_RESET : 64'h0);
         end
      end
   endtask

   task automatic test_write_e();
      we_e = 1'b1; dst_e = 4'd3; val_e = 64'h1234;
      tick();
      we_e = 1'b0; src_a = 4'd3; src_b = 4'hF;
      tick();
      n_chk++;
      if (val_a !== 64'h1234) begin n_fail++; $display("FAIL write_e_val_a got %h want 1234", val_a); end
      n_chk++;
      if (val_b !== 64'h0) begin n_fail++; $display("FAIL rnone_val_b got %h want 0", val_b); end
   endtask

   task automatic test_m_priority();
      we_e = 1'b1; dst_e = 4'd4; val_e = 64'h8;
      we_m = 1'b1; dst_m = 4'd4; val_m = 64'hAA;
      tick();
      we_e = 1'b0; we_m = 1'b0; dbg_id = 4'd4;
      #1;
      n_chk++;
      if (dbg_data !== 64'hAA) begin n_fail++; $display("FAIL m_priority got %h want aa", dbg_data); end
   endtask

   task automatic test_bypass();
      we_e = 1'b1; dst_e = 4'd2; val_e = 64'h55; src_a = 4'd2;
      tick();
      we_e = 1'b0;
      n_chk++;
      if (val_a !== 64'h55) begin n_fail++; $display("FAIL bypass_e got %h want 55", val_a); end
      we_m = 1'b1; dst_m = 4'd7; val_m = 64'h77; we_e = 1'b1; dst_e = 4'd7; val_e = 64'h11; src_b = 4'd7;
      tick();
      we_m = 1'b0; we_e = 1'b0;
      n_chk++;
      if (val_b !== 64'h77) begin n_fail++; $display("FAIL bypass_m_over_e got %h want 77", val_b); end
   endtask

   task automatic test_hold();
      logic [3:0] seq [3];
      seq[0] = 4'd2; seq[1] = 4'd4; seq[2] = 4'd0;
      rd_en = 1'b1; src_a = 4'd3;
      tick();
      rd_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         src_a = seq[k];
         tick();
         n_chk++;
         if (val_a !== 64'h1234) begin n_fail++; $display("FAIL hold[%0d] got %h want 1234", k, val_a); end
      end
      rd_en = 1'b1; src_a = 4'd4;
      tick();
      n_chk++;
      if (val_a !== 64'hAA) begin n_fail++; $display("FAIL hold_release got %h want aa", val_a); end
   endtask

   task automatic test_reset_discard();
      we_e = 1'b1; dst_e = 4'd5; val_e = 64'h7;
      tick();
      we_e = 1'b0; dbg_id = 4'd5;
      #1;
      n_chk++;
      if (dbg_data !== 64'h7) begin n_fail++; $display("FAIL pre_reset_r5 got %h want 7", dbg_data); end
      rst_n = 1'b0; we_m = 1'b1; dst_m = 4'd6; val_m = 64'hDEAD;
      tick();
      rst_n = 1'b1; we_m = 1'b0;
      n_chk++;
      if (dbg_data !== 64'h0) begin n_fail++; $display("FAIL reset_r5 got %h want 0", dbg_data); end
      dbg_id = 4'd6;
      #1;
      n_chk++;
      if (dbg_data !== 64'h0) begin n_fail++; $display("FAIL reset_r6 got %h want 0", dbg_data); end
      n_chk++;
      if (val_a !== 64'h0) begin n_fail++; $display("FAIL reset_discard_val_a got %h want 0", val_a); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         rd_en = ($urandom_range(0, 3) != 0);
         we_e  = $urandom_range(0, 1) == 1;
         we_m  = $urandom_range(0, 1) == 1;
         dst_e = 4'($urandom_range(0, 15));
         dst_m = ($urandom_range(0, 3) == 0) ? dst_e : 4'($urandom_range(0, 15));
         src_a = ($urandom_range(0, 2) == 0) ? dst_e : 4'($urandom_range(0, 15));
         src_b = ($urandom_range(0, 2) == 0) ? dst_m : 4'($urandom_range(0, 15));
         val_e = {$urandom, $urandom};
         val_m = {$urandom, $urandom};
         tick();
         n_chk++;
         if (val_a !== exp_a) begin n_fail++; $display("FAIL rand_val_a cyc %0d got %h want %h", c, val_a, exp_a); end
         n_chk++;
         if (val_b !== exp_b) begin n_fail++; $display("FAIL rand_val_b cyc %0d got %h want %h", c, val_b, exp_b); end
         dbg_id = 4'($urandom_range(0, 15));
         #1;
         n_chk++;
         if (dbg_data !== mdl_rd(dbg_id)) begin
            n_fail++;
            $display("FAIL rand_dbg cyc %0d id %0d got %h want %h", c, dbg_id, dbg_data, mdl_rd(dbg_id));
         end
      end
      we_e = 1'b0; we_m = 1'b0; rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_e();
      test_m_priority();
      test_bypass();
      test_hold();
      test_reset_discard();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
